// File: rtl/axis_pipe_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : axis_pipe_share_arb
// Purpose  : Packet-level round-robin arbiter that time-shares one AXI-Stream
//            processing pipeline among NUM_PORTS requesters. A FIFO of source
//            IDs (one entry per packet in flight) steers the returning stream
//            back to the port that originated each packet.
// Revision : 1.0 - initial release
// ============================================================================
module axis_pipe_share_arb #(
  parameter int WIDTH      = 32,
  parameter int NUM_PORTS  = 4,
  parameter int ID_W       = $clog2(NUM_PORTS),
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  // requester side
  input  logic [NUM_PORTS*WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS-1:0]          s_axis_tlast,
  input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
  output logic [NUM_PORTS-1:0]          s_axis_tready,
  // towards the shared pipeline
  output logic [WIDTH-1:0]              m_pipe_tdata,
  output logic                          m_pipe_tlast,
  output logic                          m_pipe_tvalid,
  input  logic                          m_pipe_tready,
  // back from the shared pipeline
  input  logic [WIDTH-1:0]              s_pipe_tdata,
  input  logic                          s_pipe_tlast,
  input  logic                          s_pipe_tvalid,
  output logic                          s_pipe_tready,
  // returned per-port streams
  output logic [NUM_PORTS*WIDTH-1:0]    m_axis_tdata,
  output logic [NUM_PORTS-1:0]          m_axis_tlast,
  output logic [NUM_PORTS-1:0]          m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]          m_axis_tready,
  // status
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   inflight,
  output logic                          err_orphan
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0]    c_idle  = 1'b0;
  localparam logic [0:0]    c_pass  = 1'b1;
  localparam logic [CW-1:0] c_depth = CW'(FIFO_DEPTH);

  logic [0:0]      r_state;
  logic [0:0]      w_next;
  logic [ID_W-1:0] r_grant;
  logic [ID_W-1:0] r_last;
  logic [ID_W-1:0] w_pick;
  logic [ID_W-1:0] w_cand;
  logic            w_found;
  logic            w_push;
  logic            w_pop;
  logic            w_fwd_fire;
  logic            w_empty;
  logic [ID_W-1:0] w_head;
  logic [ID_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_err;

  // Round-robin search: first valid port after the last granted one, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_cand = ID_W'((int'(r_last) + i) % NUM_PORTS);
      if (!w_found && s_axis_tvalid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Grant only from IDLE and only while the ID FIFO (registered count) has room;
  // a same-cycle pop is deliberately not allowed to free a slot for this decision.
  assign w_push     = (r_state == c_idle) && w_found && (r_count < c_depth);
  assign w_fwd_fire = (r_state == c_pass) && s_axis_tvalid[r_grant] && m_pipe_tready;
  assign w_empty    = (r_count == '0);
  assign w_head     = r_mem[r_rptr];
  assign w_pop      = !w_empty && s_pipe_tvalid && s_pipe_tready && s_pipe_tlast;

  // Arbiter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Arbiter next state: IDLE grants for one cycle, PASS holds until the granted tlast.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (w_push) w_next = c_pass;
      c_pass:  if (w_fwd_fire && s_axis_tlast[r_grant]) w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  // Arbiter outputs: forward mux of the granted port, ready only to that port.
  always_comb begin
    m_pipe_tdata  = s_axis_tdata[int'(r_grant)*WIDTH +: WIDTH];
    m_pipe_tlast  = s_axis_tlast[r_grant];
    m_pipe_tvalid = 1'b0;
    s_axis_tready = '0;
    busy          = 1'b0;
    if (r_state == c_pass) begin
      m_pipe_tvalid          = s_axis_tvalid[r_grant];
      s_axis_tready[r_grant] = m_pipe_tready;
      busy                   = 1'b1;
    end
  end

  // Current grant and the round-robin pointer (updated at end of each packet).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant <= '0;
      r_last  <= ID_W'(NUM_PORTS - 1);
    end else begin
      if (w_push) begin
        r_grant <= w_pick;
      end
      if (w_fwd_fire && s_axis_tlast[r_grant]) begin
        r_last <= r_grant;
      end
    end
  end

  // ID FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ID FIFO storage; contents are only ever read while the count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_pick;
    end
  end

  // Return demux: head ID steers the returning beat; with no owner, beats are sunk.
  always_comb begin
    m_axis_tvalid = '0;
    s_pipe_tready = 1'b1;
    if (!w_empty) begin
      m_axis_tvalid[w_head] = s_pipe_tvalid;
      s_pipe_tready         = m_axis_tready[w_head];
    end
  end

  assign m_axis_tdata = {NUM_PORTS{s_pipe_tdata}};
  assign m_axis_tlast = {NUM_PORTS{s_pipe_tlast}};

  // Sticky flag for return beats that arrive with no packet outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_empty && s_pipe_tvalid) begin
      r_err <= 1'b1;
    end
  end

  assign grant_id   = r_grant;
  assign inflight   = r_count;
  assign err_orphan = r_err;

endmodule
`default_nettype wire
